// File: rtl/alu_issue_stage.sv
// alu_issue_stage: queues ALU commands in a small FIFO, issues one at a time
// onto registered ALU inputs, captures the result and offers it downstream.
// Optional: define ALU_ISSUE_PERF_CNT_EN to add the saturating done_cnt_o
// result-handshake counter.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic [2:0]     cmd_op_i,
    input  logic [W-1:0]   cmd_a_i,
    input  logic [W-1:0]   cmd_b_i,
    output logic [2:0]     alu_op_o,
    output logic [W-1:0]   alu_a_o,
    output logic [W-1:0]   alu_b_o,
    input  logic [W-1:0]   alu_res_i,
    output logic           res_valid_o,
    input  logic           res_ready_i,
    output logic [W-1:0]   res_data_o,
    output logic [2:0]     res_op_o
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [15:0]    done_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 + 2 * W;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t         state;
    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           empty;
    logic           push;
    logic           load;
    logic [EW-1:0]  head;

    assign empty       = (count == '0);
    assign cmd_ready_o = (count != FULL_CNT);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign head        = mem[rd_ptr];
    // The FIFO only pops when the issue registers take the head entry.
    assign load        = !empty && ((state == IDLE) || (state == HOLD && res_ready_i));

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op_i, cmd_a_i, cmd_b_i};
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue/capture sequencer with registered ALU drive and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            alu_op_o    <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            res_data_o  <= '0;
            res_op_o    <= '0;
            res_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        {alu_op_o, alu_a_o, alu_b_o} <= head;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_o  <= alu_res_i;
                    res_op_o    <= alu_op_o;
                    res_valid_o <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        if (load) begin
                            {alu_op_o, alu_a_o, alu_b_o} <= head;
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    // Count delivered results, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt_o <= '0;
        end else if (res_valid_o && res_ready_i && done_cnt_o != 16'hFFFF) begin
            done_cnt_o <= done_cnt_o + 16'd1;
        end
    end
`endif

endmodule
